// File: rtl/qc_seq.sv
// Sequential branch-condition compare: scans SLICE-bit slices MSB-first, one per clock.
// Latency: NSL cycles from accept to out_valid, or k+1 when EARLY_EXIT and slice k is the first to differ.
// Backpressure: single op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module qc_seq #(
    parameter int WIDTH      = 32,
    parameter int SLICE      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  RSbus,
    input  logic [WIDTH-1:0]                  RTbus,
    input  logic [2:0]                        op,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              Result,
    output logic [$clog2(WIDTH/SLICE):0]      cycles
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int CW  = $clog2(NSL) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        op_q;
    logic              eq_q, lt_q;
    logic [IW-1:0]     idx_q;

    logic [SLICE-1:0]  a_sl, b_sl;
    logic              diff, first_diff, eq_n, lt_n, finish, accept, res_n;
    logic              sgn_op, z_op;
    logic [WIDTH-1:0]  a_in, b_in;

    // Operands shift left each cycle, so the slice under test is always the top one.
    assign a_sl       = a_q[WIDTH-1 -: SLICE];
    assign b_sl       = b_q[WIDTH-1 -: SLICE];
    assign diff       = (a_sl != b_sl);
    // Only the most significant differing slice decides the ordering.
    assign first_diff = eq_q & diff;
    assign eq_n       = eq_q & ~diff;
    assign lt_n       = first_diff ? (a_sl < b_sl) : lt_q;
    assign finish     = (idx_q == IW'(NSL - 1)) || ((EARLY_EXIT != 0) && first_diff);

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = (state == IDLE) && in_valid && !flush;

    assign z_op   = (op >= 3'd2) && (op <= 3'd5);
    assign sgn_op = (op >= 3'd2) && (op <= 3'd6);
    // Flipping both sign bits turns a signed compare into an unsigned one.
    assign a_in   = RSbus ^ {sgn_op, {(WIDTH-1){1'b0}}};
    assign b_in   = (z_op ? {WIDTH{1'b0}} : RTbus) ^ {sgn_op, {(WIDTH-1){1'b0}}};

    always_comb begin
        res_n = 1'b0;
        case (op_q)
            3'd0:    res_n = ~eq_n;
            3'd1:    res_n = eq_n;
            3'd2:    res_n = lt_n | eq_n;
            3'd3:    res_n = ~lt_n & ~eq_n;
            3'd4:    res_n = ~lt_n;
            default: res_n = lt_n;
        endcase
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)  state_n = BUSY;
                BUSY:    if (finish)    state_n = DONE;
                DONE:    if (out_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            idx_q  <= '0;
            Result <= 1'b0;
            cycles <= '0;
        end else if (accept) begin
            a_q   <= a_in;
            b_q   <= b_in;
            op_q  <= op;
            eq_q  <= 1'b1;
            lt_q  <= 1'b0;
            idx_q <= '0;
        end else if ((state == BUSY) && !flush) begin
            a_q   <= a_q << SLICE;
            b_q   <= b_q << SLICE;
            eq_q  <= eq_n;
            lt_q  <= lt_n;
            idx_q <= idx_q + IW'(1);
            if (finish) begin
                Result <= res_n;
                cycles <= CW'(idx_q) + CW'(1);
            end
        end
    end

endmodule

// File: doc/qc_seq.md
Name: qc_seq

Overview:
Parametrised, sequential successor to the combinational quick-compare unit. It evaluates branch conditions on WIDTH-bit operands by scanning SLICE-bit slices MSB-first, one slice per clock, with optional early exit. It adds signed and unsigned less-than modes, a valid/ready handshake on both sides, and a flush input. It sits in the EX stage beside the ALU and is fed from the bypass-mux outputs. Its result drives branch resolution.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of SLICE.
SLICE, 8, bits compared per cycle; NSL = WIDTH/SLICE slices.
EARLY_EXIT, 1, when 1, finish as soon as a slice differs.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous reset, active-high.
flush  input  1  synchronous kill of the in-flight or held operation.
in_valid  input  1  operands and op are valid.
in_ready  output  1  unit can accept a new operation.
RSbus  input  WIDTH  S operand.
RTbus  input  WIDTH  T operand; ignored for the *Z ops.
op  input  3  0 NE, 1 EQ, 2 LEZ, 3 GTZ, 4 GEZ, 5 LTZ, 6 LT (signed RS<RT), 7 LTU (unsigned RS<RT).
out_valid  output  1  Result is valid.
out_ready  input  1  consumer takes Result.
Result  output  1  comparison outcome.
cycles  output  log2(NSL)+1  number of slices consumed by the last completed op.

Behaviour:
- States: IDLE, BUSY, DONE. Reset drives state to IDLE, in_ready=1, out_valid=0, Result=0, cycles=0, and clears all internal registers.
- in_ready = (state==IDLE). There is no accept in BUSY or DONE.
- Accept (IDLE, in_valid=1):
  - Latch A=RSbus and op.
  - Latch B=RTbus for ops 0,1,6,7; latch B=0 for ops 2–5.
  - For the signed ops (2–6), invert the MSB of both A and B, so every op becomes an unsigned compare.
  - Set eq=1, lt=0, idx=0. Go to BUSY.
- BUSY, each edge, process slice idx (slice 0 = bits WIDTH-1..WIDTH-SLICE):
  - If the slices differ: lt = (A slice < B slice), eq=0.
  - idx increments.
  - Finish when idx==NSL-1 was just processed, or when EARLY_EXIT=1 and the slice differed.
  - On finish: go to DONE, set out_valid=1, cycles=idx+1, Result registered in the same edge.
- Result mapping:
  - NE: !eq. EQ: eq.
  - LEZ: lt|eq. GTZ: !lt&!eq.
  - GEZ: !lt. LTZ: lt.
  - LT and LTU: lt.
- Latency from the accept edge to out_valid high: NSL edges, or k+1 edges if the first differing slice is k and EARLY_EXIT=1.
- DONE: hold Result, cycles and out_valid stable until out_ready=1. On that edge out_valid goes to 0 and state returns to IDLE, so in_ready is high the next cycle. Result and cycles keep their values.
- flush=1 on any edge:
  - Go to IDLE with out_valid=0. Result and cycles are unchanged.
  - flush overrides completion, out_ready and accept in the same cycle.
- Reset asserted mid-operation: immediate return to the reset values, with no output pulse.
- in_valid while not in IDLE is ignored. The producer must hold its values until in_ready.
- Operand changes after accept have no effect.
- SLICE==WIDTH degenerates to a 1-cycle compare (NSL=1).

Test Plan:
- Equality, full scan (defaults): op=1 (EQ), RS=RT=0x12345678 → out_valid 4 cycles after accept, Result=1, cycles=4. Repeat with op=0 (NE) → Result=0.
- Early exit: op=0 (NE), RS=0xFF000000, RT=0x00000000 → out_valid 1 cycle after accept, Result=1, cycles=1. With EARLY_EXIT=0, the same operands → 4 cycles, cycles=4.
- Signed versus unsigned:
  - RS=0xFFFFFFFF, RT=0x00000001, op=6 (LT) → Result=1; op=7 (LTU) → Result=0.
  - op=2 (LEZ) with RS=0 → 1; op=3 (GTZ) with RS=0x80000000 → 0; op=4 (GEZ) with RS=0x7FFFFFFF → 1.
- Back-pressure: hold out_ready=0 for 5 cycles after completion → out_valid, Result and cycles stay constant and in_ready=0. Assert out_ready → IDLE next cycle, and a new op is accepted the following edge.
- Flush mid-BUSY: flush on cycle 2 of a 4-cycle op → out_valid never rises, in_ready=1 next cycle. A flush in DONE with out_ready=1 in the same cycle → no handshake completes.
- Async reset during BUSY: assert reset between clock edges → out_valid=0, in_ready=1 immediately, cycles=0. Then run randomized ops for WIDTH=16/SLICE=4 and WIDTH=64/SLICE=16 against a reference model.
